// File: rtl/rtc_mtimer_pkg.sv
// Shared types and default widths for the multi-channel RTC timer.
package rtc_mtimer_pkg;
  localparam int RTC_MTIMER_CNT_W   = 17;
  localparam int RTC_MTIMER_PRESC_W = 10;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;
endpackage

// File: rtl/rtc_mtimer_ch.sv
// One timer channel: IDLE/RUN/DONE FSM, up-counter, target compare and
// registered event pulse plus sticky pending flag.
module rtc_mtimer_ch
  import rtc_mtimer_pkg::*;
#(
  parameter int CNT_W = RTC_MTIMER_CNT_W
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             tick_i,
  input  logic             pause_i,
  input  logic             update_i,
  input  logic             enable_i,
  input  logic             retrig_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic             event_clr_i,
  output logic [CNT_W-1:0] value_o,
  output logic             event_o,
  output logic             pending_o
);
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] value_q, value_d, target_q, target_d, nxt;
  logic             retrig_q, retrig_d, expire;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= CH_IDLE;
      value_q   <= '0;
      target_q  <= '0;
      retrig_q  <= 1'b0;
      event_o   <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      target_q  <= target_d;
      retrig_q  <= retrig_d;
      event_o   <= expire;
      // a coincident set beats the clear
      pending_o <= expire | (pending_o & ~event_clr_i);
    end
  end

  // target 0 falls out naturally: next >= 0 expires on the first tick
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    target_d = target_q;
    retrig_d = retrig_q;
    expire   = 1'b0;
    nxt      = value_q + CNT_W'(1);
    if (update_i) begin
      target_d = target_i;
      retrig_d = retrig_i;
      value_d  = '0;
      state_d  = enable_i ? CH_RUN : CH_IDLE;
    end else begin
      case (state_q)
        CH_RUN: begin
          if (tick_i && !pause_i) begin
            if (nxt >= target_q) begin
              expire = 1'b1;
              if (retrig_q) begin
                value_d = '0;
              end else begin
                value_d = nxt;
                state_d = CH_DONE;
              end
            end else begin
              value_d = nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign value_o = value_q;
endmodule

// File: rtl/rtc_multi_timer.sv
// Multi-channel RTC timer: shared prescaler tick feeding NUM_CH channels.
// Define RTC_MTIMER_PAUSE_EN to add the per-channel pause_i input.
module rtc_multi_timer
  import rtc_mtimer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = RTC_MTIMER_CNT_W,
  parameter int PRESC_W = RTC_MTIMER_PRESC_W
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [PRESC_W-1:0]      tick_div_i,
  input  logic [NUM_CH-1:0]       cfg_update_i,
  input  logic [NUM_CH-1:0]       cfg_enable_i,
  input  logic [NUM_CH-1:0]       cfg_retrig_i,
  input  logic [NUM_CH*CNT_W-1:0] cfg_target_i,
`ifdef RTC_MTIMER_PAUSE_EN
  input  logic [NUM_CH-1:0]       pause_i,
`endif
  output logic [NUM_CH*CNT_W-1:0] value_o,
  output logic [NUM_CH-1:0]       event_o,
  output logic [NUM_CH-1:0]       pending_o,
  input  logic [NUM_CH-1:0]       event_clr_i,
  output logic                    event_any_o
);
  logic [PRESC_W-1:0] presc_q;
  logic               tick;
  logic [NUM_CH-1:0]  pause_w;

`ifdef RTC_MTIMER_PAUSE_EN
  assign pause_w = pause_i;
`else
  assign pause_w = '0;
`endif

  // >= so a divider lowered below the running count wraps immediately
  assign tick = (presc_q >= tick_div_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q     <= '0;
      event_any_o <= 1'b0;
    end else begin
      presc_q     <= tick ? '0 : presc_q + PRESC_W'(1);
      event_any_o <= |pending_o;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rtc_mtimer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .tick_i      (tick),
      .pause_i     (pause_w[k]),
      .update_i    (cfg_update_i[k]),
      .enable_i    (cfg_enable_i[k]),
      .retrig_i    (cfg_retrig_i[k]),
      .target_i    (cfg_target_i[k*CNT_W +: CNT_W]),
      .event_clr_i (event_clr_i[k]),
      .value_o     (value_o[k*CNT_W +: CNT_W]),
      .event_o     (event_o[k]),
      .pending_o   (pending_o[k])
    );
  end
endmodule

// File: tb/tb_rtc_multi_timer.sv
// Self-checking bench for rtc_multi_timer: event scoreboard plus directed value checks.
module tb_rtc_multi_timer;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 17;
  localparam int PRESC_W = 10;

  logic                    clk_i = 1'b0;
  logic                    rstn_i = 1'b0;
  logic [PRESC_W-1:0]      tick_div_i = '0;
  logic [NUM_CH-1:0]       cfg_update_i = '0, cfg_enable_i = '0, cfg_retrig_i = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_target_i = '0;
  logic [NUM_CH*CNT_W-1:0] value_o;
  logic [NUM_CH-1:0]       event_o, pending_o;
  logic [NUM_CH-1:0]       event_clr_i = '0;
  logic                    event_any_o;
`ifdef RTC_MTIMER_PAUSE_EN
  logic [NUM_CH-1:0]       pause_i = '0;
`endif

  rtc_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .tick_div_i   (tick_div_i),
    .cfg_update_i (cfg_update_i),
    .cfg_enable_i (cfg_enable_i),
    .cfg_retrig_i (cfg_retrig_i),
    .cfg_target_i (cfg_target_i),
`ifdef RTC_MTIMER_PAUSE_EN
    .pause_i      (pause_i),
`endif
    .value_o      (value_o),
    .event_o      (event_o),
    .pending_o    (pending_o),
    .event_clr_i  (event_clr_i),
    .event_any_o  (event_any_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int ch; int cyc; } exp_evt_t;
  exp_evt_t sb[$];
  int cyc = 0, c0 = 0, n_chk = 0, n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc - c0);
    end
  endtask

  function automatic int val(input int k);
    return int'(value_o[k*CNT_W +: CNT_W]);
  endfunction

  // event monitor: every pulse must match the head of the scoreboard
  always @(negedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (event_o[k]) begin
        if (sb.size() == 0) chk("evt_unexpected_ch", k, -1);
        else begin
          exp_evt_t e;
          e = sb.pop_front();
          chk("evt_ch", k, e.ch);
          chk("evt_cyc", cyc - c0, e.cyc - c0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_rel(input int rel);
    while (cyc < c0 + rel) step();
  endtask

  task automatic expect_evt(input int k, input int rel);
    exp_evt_t e;
    e.ch = k; e.cyc = c0 + rel;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int div);
    rstn_i = 1'b0;
    cfg_update_i = '0; cfg_enable_i = '0; cfg_retrig_i = '0; event_clr_i = '0;
`ifdef RTC_MTIMER_PAUSE_EN
    pause_i = '0;
`endif
    tick_div_i = PRESC_W'(div);
    repeat (2) step();
    rstn_i = 1'b1;
    c0 = cyc;
  endtask

  task automatic set_upd(input int k, input bit en, input bit rt, input int tgt);
    logic [CNT_W-1:0] t;
    t = CNT_W'(tgt);
    cfg_update_i[k] = 1'b1;
    cfg_enable_i[k] = en;
    cfg_retrig_i[k] = rt;
    cfg_target_i[k*CNT_W +: CNT_W] = t;
  endtask

  task automatic upd_pulse();
    step();
    cfg_update_i = '0;
  endtask

  int exp2[6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    // reset state
    do_reset(3);
    chk("rst_value", longint'(value_o), 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_event", event_o, 0);
    chk("rst_any", event_any_o, 0);

    // one-shot: ticks in cycles 3,7,..,19; expiry pulse in cycle 20
    set_upd(0, 1, 0, 5); upd_pulse();
    expect_evt(0, 20);
    wait_rel(8);  chk("os_val_mid", val(0), 2);
    wait_rel(20); chk("os_val_done", val(0), 5);
    chk("os_pend", pending_o[0], 1);
    chk("os_any_lag", event_any_o, 0);
    wait_rel(21); chk("os_any", event_any_o, 1);
    wait_rel(22); event_clr_i[0] = 1'b1; step(); event_clr_i = '0;
    chk("os_pend_clr", pending_o[0], 0);
    chk("os_any_still", event_any_o, 1);
    step(); chk("os_any_clr", event_any_o, 0);
    wait_rel(28); chk("os_done_hold", val(0), 5);

    // retrigger every 3 ticks at one tick per cycle
    do_reset(0);
    set_upd(1, 1, 1, 3); upd_pulse();
    expect_evt(1, 4); expect_evt(1, 7); expect_evt(1, 10); expect_evt(1, 13);
    for (int i = 0; i < 6; i++) begin
      wait_rel(2 + i);
      chk("rt_val", val(1), exp2[i]);
    end
    wait_rel(13);
    set_upd(1, 0, 0, 3); upd_pulse();
    chk("rt_stop_val", val(1), 0);
    wait_rel(20); chk("rt_idle_val", val(1), 0);

    // update vs tick, clear vs set
    do_reset(0);
    set_upd(2, 1, 0, 5); upd_pulse();
    wait_rel(4); chk("pr_val_pre", val(2), 3);
    set_upd(2, 1, 0, 5); upd_pulse();
    chk("pr_upd_wins", val(2), 0);
    expect_evt(2, 10);
    wait_rel(9); event_clr_i[2] = 1'b1; step(); event_clr_i = '0;
    chk("pr_set_wins", pending_o[2], 1);
    step(); chk("pr_pend_hold", pending_o[2], 1);
    event_clr_i[2] = 1'b1; step(); event_clr_i = '0;
    chk("pr_pend_clr", pending_o[2], 0);
    chk("pr_done_val", val(2), 5);

    // prescaler shrink below running count
    do_reset(100);
    set_upd(0, 1, 0, 1000); upd_pulse();
    wait_rel(50); chk("ps_val_50", val(0), 0);
    tick_div_i = PRESC_W'(10);
    step(); chk("ps_val_51", val(0), 1);
    wait_rel(61); chk("ps_val_61", val(0), 1);
    wait_rel(62); chk("ps_val_62", val(0), 2);
    wait_rel(73); chk("ps_val_73", val(0), 3);

    // multi-channel, then async reset mid-run
    do_reset(1);
    set_upd(0, 1, 0, 2); set_upd(1, 1, 0, 2); set_upd(2, 1, 0, 4); set_upd(3, 1, 0, 0);
    upd_pulse();
    expect_evt(3, 2); expect_evt(0, 4); expect_evt(1, 4); expect_evt(2, 8);
    wait_rel(2); chk("mc_t0_val", val(3), 1);
    wait_rel(8);
    set_upd(0, 1, 0, 100); upd_pulse();
    chk("mc_pend_all", pending_o, 4'hf);
    chk("mc_any", event_any_o, 1);
    wait_rel(10); chk("mc_run_val", val(0), 1);
    rstn_i = 1'b0; #1;
    chk("mc_rst_value", longint'(value_o), 0);
    chk("mc_rst_pend", pending_o, 0);
    chk("mc_rst_any", event_any_o, 0);
    step(); rstn_i = 1'b1; c0 = cyc;
    wait_rel(10);
    chk("mc_idle_value", longint'(value_o), 0);
    chk("mc_idle_pend", pending_o, 0);

`ifdef RTC_MTIMER_PAUSE_EN
    // pause after 4 ticks for 20 cycles, expiry 6 ticks after release
    do_reset(0);
    set_upd(0, 1, 0, 10); upd_pulse();
    expect_evt(0, 31);
    wait_rel(5); chk("pa_val_pre", val(0), 4);
    pause_i[0] = 1'b1;
    wait_rel(15); chk("pa_hold_15", val(0), 4);
    wait_rel(25); chk("pa_hold_25", val(0), 4);
    pause_i[0] = 1'b0;
    step(); chk("pa_resume", val(0), 5);
    wait_rel(34); chk("pa_done_val", val(0), 10);
`endif

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
